rib_arbiter_xbar: RTL and testbench
===================================

# rib_arbiter_xbar

Parametrised successor to the fixed 4-master/8-slave RIB interconnect. It connects NUM_M bus masters (core data port, core PC fetch, JTAG, UART debug) to NUM_S slaves over a shared address/data path. Arbitration is either fixed-priority or round-robin, selected by parameter. Slave responses use a req/ready handshake with a timeout, and unmapped or unresponsive accesses complete with an error. It sits between the core(s) and the peripheral slaves in the SoC top and drives the core hold flag.

## Interface
Parameters:
- NUM_M, 4: number of masters (2..8)
- NUM_S, 8: number of slaves (1..16)
- AW, 32: address width
- DW, 32: data width
- DEC_BITS, 4: address MSBs used as slave index
- ARB_MODE, 0: 0 = fixed priority (highest index wins), 1 = round-robin
- TIMEOUT, 255: BUSY cycles without slave ready before error completion; 0 disables

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- m_addr_i  in  NUM_M*AW  master addresses, master k at [k*AW +: AW]
- m_data_i  in  NUM_M*DW  master write data
- m_req_i  in  NUM_M  master request
- m_we_i  in  NUM_M  master write enable
- m_data_o  out  NUM_M*DW  read data; zero for non-granted masters
- m_ready_o  out  NUM_M  one-cycle completion pulse
- m_err_o  out  NUM_M  error flag, valid with m_ready_o
- s_addr_o  out  AW  slave address, full width
- s_data_o  out  DW  slave write data
- s_req_o  out  NUM_S  one-hot slave request
- s_we_o  out  NUM_S  one-hot slave write enable
- s_data_i  in  NUM_S*DW  slave read data
- s_ready_i  in  NUM_S  slave ready, tie high for zero-wait slaves
- grant_o  out  NUM_M  one-hot current grant
- hold_flag_o  out  1  stall request to core 0

## Operation
- FSM states:
  - IDLE:
    - If any m_req_i is high, register the winner into grant, latch the slave index sel = m_addr_i[g][AW-1 -: DEC_BITS], clear the counter, and go to BUSY.
    - Fixed mode: the highest-index requester wins.
    - RR mode: the first requester at or after the pointer wins, searching upward with wrap.
  - BUSY, granted master g:
    - s_addr_o, s_data_o = master g; s_req_o[sel] = m_req_i[g]; s_we_o[sel] = m_we_i[g].
    - Completion when s_ready_i[sel] is high: m_ready_o[g] = 1, m_data_o[g] = s_data_i[sel], m_err_o[g] = 0. Go to IDLE.
    - sel ≥ NUM_S: no s_req_o. Completion in the first BUSY cycle with m_err_o[g] = 1, data 0.
    - Counter reaches TIMEOUT (TIMEOUT ≠ 0) without ready: completion with m_err_o[g] = 1, data 0.
    - m_req_i[g] drops before completion: abort, no m_ready_o, go to IDLE.
- RR pointer updates to (g+1) mod NUM_M on completion or abort only.
- Masters hold addr/data/we stable from req until ready.
- hold_flag_o = |m_req_i[NUM_M-1:1] OR (BUSY and g ≠ 0).
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- Writes ignore s_data_i. Read data is never registered.

## Timing
- Reset (rst = 0, async) sets state IDLE, grant 0, pointer 0, counter 0.
- During reset, all outputs are 0 except hold_flag_o, which follows the m_req_i term.
- Reset asserted mid-BUSY drops s_req_o immediately. No completion is reported.
- Minimum latency: req high in IDLE at cycle 0, grant_o valid at cycle 1, m_ready_o at cycle 1 if the slave ready is high. Back to IDLE at cycle 2.
- Sustained throughput is one transfer per 2 cycles. A master holding req after ready is re-arbitrated in the next IDLE.
- Error via timeout: m_ready_o/m_err_o in BUSY cycle TIMEOUT+1, i.e. when the counter equals TIMEOUT.
- Requests that change in BUSY do not affect the grant until return to IDLE. No preemption.
- Simultaneous completion and timeout: the slave ready wins, with no error.

## Test plan
- Fixed mode: m_req_i = 4'b1001 in IDLE, with both addresses 0x1000_0000 and s_ready_i all 1. Expect grant_o = 4'b1000 at cycle 1 and m_ready_o[3] at cycle 1. Then grant_o = 4'b0001 at cycle 3. hold_flag_o = 1 at cycles 0-1.
- RR mode: all four masters request continuously. Grants cycle 0,1,2,3,0 at cycles 1,3,5,7,9. Each m_ready_o pulses exactly once per 8 cycles.
- Read 0x2000_0004 with s_data_i[2] = 0xDEAD_BEEF and s_ready_i[2] low for 3 BUSY cycles. Expect s_req_o = 8'b0000_0100 for 4 cycles, then m_data_o[0] = 0xDEAD_BEEF with m_ready_o[0].
- NUM_S = 8, address 0xF000_0000. Expect s_req_o = 0 and m_ready_o = 1 with m_err_o = 1 at cycle 1.
- TIMEOUT = 4, slave ready stuck low. Expect m_err_o at the 5th BUSY cycle, data 0. Then IDLE.
- Assert rst low mid-BUSY. Expect s_req_o, grant_o and m_ready_o at 0 in the same cycle. After release, the first request completes normally.

Source files
------------

// File: rtl/rib_arbiter_xbar.sv
// Shared-bus interconnect: NUM_M masters arbitrated onto one address/data path,
// decoded to NUM_S slaves by the top DEC_BITS address bits, with timeout/error completion.
module rib_arbiter_xbar #(
  parameter int NUM_M    = 4,
  parameter int NUM_S    = 8,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEC_BITS = 4,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  output logic [NUM_M*DW-1:0] m_data_o,
  output logic [NUM_M-1:0]    m_ready_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_data_o,
  output logic [NUM_S-1:0]    s_req_o,
  output logic [NUM_S-1:0]    s_we_o,
  input  logic [NUM_S*DW-1:0] s_data_i,
  input  logic [NUM_S-1:0]    s_ready_i,
  output logic [NUM_M-1:0]    grant_o,
  output logic                hold_flag_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int MP = 1 << IW;
  localparam int SP = 1 << DEC_BITS;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]     CNT_TO = CW'(TIMEOUT);
  localparam logic [DEC_BITS:0] NS_LIM = (DEC_BITS + 1)'(NUM_S);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [NUM_M-1:0]    grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [DEC_BITS-1:0] sel_q, sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       win;

  // Power-of-two padded views so the registered indices select without range checks
  logic [AW-1:0] m_addr_a [MP];
  logic [DW-1:0] m_wdat_a [MP];
  logic [MP-1:0] m_req_p, m_we_p;
  logic [DW-1:0] s_rdat_a [SP];
  logic [SP-1:0] s_rdy_p;

  genvar gi;
  generate
    for (gi = 0; gi < MP; gi++) begin : g_mpad
      if (gi < NUM_M) begin : g_real
        assign m_addr_a[gi] = m_addr_i[gi*AW +: AW];
        assign m_wdat_a[gi] = m_data_i[gi*DW +: DW];
        assign m_req_p[gi]  = m_req_i[gi];
        assign m_we_p[gi]   = m_we_i[gi];
      end else begin : g_zero
        assign m_addr_a[gi] = '0;
        assign m_wdat_a[gi] = '0;
        assign m_req_p[gi]  = 1'b0;
        assign m_we_p[gi]   = 1'b0;
      end
    end
    for (gi = 0; gi < SP; gi++) begin : g_spad
      if (gi < NUM_S) begin : g_real
        assign s_rdat_a[gi] = s_data_i[gi*DW +: DW];
        assign s_rdy_p[gi]  = s_ready_i[gi];
      end else begin : g_zero
        assign s_rdat_a[gi] = '0;
        assign s_rdy_p[gi]  = 1'b0;
      end
    end
  endgenerate

  logic busy, req_g, we_g, mapped, timeout_hit, ok_done, err_done, done, abort;
  logic [DW-1:0] rdata;

  assign busy        = (state_q == BUSY);
  assign req_g       = m_req_p[gidx_q];
  assign we_g        = m_we_p[gidx_q];
  assign mapped      = ({1'b0, sel_q} < NS_LIM);
  assign rdata       = s_rdat_a[sel_q];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_TO);
  // Slave ready beats a timeout landing in the same cycle
  assign ok_done     = busy && req_g && mapped && s_rdy_p[sel_q];
  assign err_done    = busy && req_g && !ok_done && (!mapped || timeout_hit);
  assign done        = ok_done || err_done;
  assign abort       = busy && !req_g;

  always_comb begin
    int j;
    win = '0;
    j   = 0;
    if (ARB_MODE == 1) begin
      // Walk downward so the requester closest at/after the pointer is assigned last
      for (int k = NUM_M - 1; k >= 0; k--) begin
        j = int'(ptr_q) + k;
        if (j >= NUM_M) j = j - NUM_M;
        if (m_req_p[IW'(j)]) win = IW'(j);
      end
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        if (m_req_p[IW'(k)]) win = IW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (!busy) begin
      if (|m_req_i) begin
        state_d = BUSY;
        gidx_d  = win;
        grant_d = NUM_M'(1) << win;
        sel_d   = m_addr_a[win][AW-1 -: DEC_BITS];
        cnt_d   = '0;
      end
    end else if (done || abort) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d   = '0;
      ptr_d   = (gidx_q == IW'(NUM_M - 1)) ? '0 : gidx_q + 1'b1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign s_addr_o    = busy ? m_addr_a[gidx_q] : '0;
  assign s_data_o    = busy ? m_wdat_a[gidx_q] : '0;
  assign hold_flag_o = (|m_req_i[NUM_M-1:1]) || (busy && (gidx_q != '0));

  generate
    for (gi = 0; gi < NUM_S; gi++) begin : g_sout
      assign s_req_o[gi] = busy && req_g && (sel_q == DEC_BITS'(gi));
      assign s_we_o[gi]  = busy && we_g && (sel_q == DEC_BITS'(gi));
    end
    for (gi = 0; gi < NUM_M; gi++) begin : g_mout
      assign m_ready_o[gi]          = done && (gidx_q == IW'(gi));
      assign m_err_o[gi]            = err_done && (gidx_q == IW'(gi));
      assign m_data_o[gi*DW +: DW]  = (ok_done && !we_g && (gidx_q == IW'(gi))) ? rdata : '0;
    end
  endgenerate

endmodule

// File: tb/tb_rib_arbiter_xbar.sv
// Directed bench: one fixed-priority instance (TIMEOUT=4) and one round-robin
// instance share the same stimulus; each step checks the relevant instance.
module tb_rib_arbiter_xbar;
  localparam int NM = 4, NS = 8, AW = 32, DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_req, m_we;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ready;

  logic [NM*DW-1:0] f_data, r_data;
  logic [NM-1:0]    f_ready, f_err, f_grant, r_ready, r_err, r_grant;
  logic [AW-1:0]    f_saddr, r_saddr;
  logic [DW-1:0]    f_sdata, r_sdata;
  logic [NS-1:0]    f_sreq, f_swe, r_sreq, r_swe;
  logic             f_hold, r_hold;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rib_arbiter_xbar #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .DEC_BITS(4),
                     .ARB_MODE(0), .TIMEOUT(4)) u_fix (
    .clk(clk), .rst(rst), .m_addr_i(m_addr), .m_data_i(m_wdata), .m_req_i(m_req),
    .m_we_i(m_we), .m_data_o(f_data), .m_ready_o(f_ready), .m_err_o(f_err),
    .s_addr_o(f_saddr), .s_data_o(f_sdata), .s_req_o(f_sreq), .s_we_o(f_swe),
    .s_data_i(s_rdata), .s_ready_i(s_ready), .grant_o(f_grant), .hold_flag_o(f_hold));

  rib_arbiter_xbar #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .DEC_BITS(4),
                     .ARB_MODE(1), .TIMEOUT(255)) u_rr (
    .clk(clk), .rst(rst), .m_addr_i(m_addr), .m_data_i(m_wdata), .m_req_i(m_req),
    .m_we_i(m_we), .m_data_o(r_data), .m_ready_o(r_ready), .m_err_o(r_err),
    .s_addr_o(r_saddr), .s_data_o(r_sdata), .s_req_o(r_sreq), .s_we_o(r_swe),
    .s_data_i(s_rdata), .s_ready_i(s_ready), .grant_o(r_grant), .hold_flag_o(r_hold));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    m_req   = '0;
    m_we    = '0;
    s_ready = '1;
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int rdy_cnt [NM];
    logic [NM-1:0] exp_g;

    m_addr  = '0;
    m_wdata = '0;
    m_req   = '0;
    m_we    = '0;
    s_ready = '1;
    for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = 32'hA000_0000 + 32'(k);

    // Reset state
    #3;
    chk("rst_grant", f_grant, 0);
    chk("rst_sreq", f_sreq, 0);
    chk("rst_ready", f_ready, 0);
    chk("rst_hold", f_hold, 0);
    m_req = 4'b0100;
    #1;
    chk("rst_hold_follow", f_hold, 1);
    m_req = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Fixed priority: masters 3 and 0 both request
    for (int k = 0; k < NM; k++) m_addr[k*AW +: AW] = 32'h1000_0000;
    m_req = 4'b1001;
    #1;
    chk("fx_c0_grant", f_grant, 0);
    chk("fx_c0_hold", f_hold, 1);
    next_cycle();
    #1;
    chk("fx_c1_grant", f_grant, 4'b1000);
    chk("fx_c1_ready", f_ready, 4'b1000);
    chk("fx_c1_err", f_err, 0);
    chk("fx_c1_sreq", f_sreq, 8'b0000_0010);
    chk("fx_c1_data", f_data, {32'hA000_0001, 96'h0});
    chk("fx_c1_hold", f_hold, 1);
    $display("txn fixed: master 3 read slave 1");
    next_cycle();
    m_req = 4'b0001;
    #1;
    chk("fx_c2_ready", f_ready, 0);
    chk("fx_c2_hold", f_hold, 0);
    next_cycle();
    #1;
    chk("fx_c3_grant", f_grant, 4'b0001);
    chk("fx_c3_ready", f_ready, 4'b0001);
    chk("fx_c3_data", f_data, {96'h0, 32'hA000_0001});
    $display("txn fixed: master 0 read slave 1");
    next_cycle();
    m_req = '0;

    // Round-robin: all masters request continuously
    do_reset();
    m_req = 4'b1111;
    for (int k = 0; k < NM; k++) rdy_cnt[k] = 0;
    #1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      #1;
      exp_g = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
      chk($sformatf("rr_c%0d_grant", c), r_grant, exp_g);
      chk($sformatf("rr_c%0d_ready", c), r_ready, exp_g);
      if (c <= 8) for (int k = 0; k < NM; k++) rdy_cnt[k] += int'(r_ready[k]);
      if (c % 2 == 1) $display("txn rr: cycle %0d grant %b", c, r_grant);
    end
    for (int k = 0; k < NM; k++) chk($sformatf("rr_pulses_m%0d", k), 128'(rdy_cnt[k]), 1);
    m_req = '0;

    // Wait-state read from slave 2
    do_reset();
    m_addr[0 +: AW] = 32'h2000_0004;
    s_ready = 8'b1111_1011;
    s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
    m_req = 4'b0001;
    #1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      #1;
      chk($sformatf("rd_c%0d_sreq", c), f_sreq, 8'b0000_0100);
      chk($sformatf("rd_c%0d_ready", c), f_ready, 0);
    end
    next_cycle();
    s_ready = 8'hFF;
    #1;
    chk("rd_c4_sreq", f_sreq, 8'b0000_0100);
    chk("rd_c4_saddr", f_saddr, 32'h2000_0004);
    chk("rd_c4_ready", f_ready, 4'b0001);
    chk("rd_c4_data", f_data, {96'h0, 32'hDEAD_BEEF});
    $display("txn wait read: master 0 got %h", f_data[31:0]);
    next_cycle();
    m_req = '0;
    #1;
    chk("rd_idle_grant", f_grant, 0);

    // Unmapped slave index 15
    m_addr[0 +: AW] = 32'hF000_0000;
    m_req = 4'b0001;
    #1;
    next_cycle();
    #1;
    chk("um_sreq", f_sreq, 0);
    chk("um_ready", f_ready, 4'b0001);
    chk("um_err", f_err, 4'b0001);
    chk("um_data", f_data, 0);
    $display("txn unmapped: error completion");
    next_cycle();
    m_req = '0;

    // Timeout with slave 3 ready stuck low
    do_reset();
    m_addr[0 +: AW] = 32'h3000_0000;
    s_ready = '0;
    s_rdata[3*DW +: DW] = 32'h5555_AAAA;
    m_req = 4'b0001;
    #1;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      #1;
      chk($sformatf("to_c%0d_ready", c), f_ready, 0);
      chk($sformatf("to_c%0d_sreq", c), f_sreq, 8'b0000_1000);
    end
    next_cycle();
    #1;
    chk("to_c5_ready", f_ready, 4'b0001);
    chk("to_c5_err", f_err, 4'b0001);
    chk("to_c5_data", f_data, 0);
    $display("txn timeout: error completion");
    next_cycle();
    m_req = '0;
    #1;
    chk("to_idle_grant", f_grant, 0);

    // Ready arriving in the timeout cycle wins
    m_req = 4'b0001;
    #1;
    for (int c = 1; c <= 4; c++) next_cycle();
    next_cycle();
    s_ready[3] = 1'b1;
    #1;
    chk("sim_ready", f_ready, 4'b0001);
    chk("sim_err", f_err, 0);
    chk("sim_data", f_data, {96'h0, 32'h5555_AAAA});
    $display("txn ready at timeout: normal completion");
    next_cycle();
    m_req = '0;
    s_ready = '0;

    // Abort: master 1 drops request mid-BUSY
    do_reset();
    m_addr[1*AW +: AW] = 32'h3000_0000;
    s_ready = '0;
    m_req = 4'b0010;
    #1;
    next_cycle();
    m_req = '0;
    #1;
    chk("ab_ready", f_ready, 0);
    chk("ab_hold", f_hold, 1);
    next_cycle();
    #1;
    chk("ab_grant", f_grant, 0);
    $display("txn abort: master 1 dropped request");

    // Reset asserted mid-BUSY
    do_reset();
    s_ready = '0;
    m_req = 4'b0001;
    #1;
    next_cycle();
    #1;
    chk("mr_busy_sreq", f_sreq, 8'b0000_1000);
    chk("mr_busy_grant", f_grant, 4'b0001);
    rst = 1'b0;
    #1;
    chk("mr_rst_sreq", f_sreq, 0);
    chk("mr_rst_grant", f_grant, 0);
    chk("mr_rst_ready", f_ready, 0);
    chk("mr_rst_saddr", f_saddr, 0);
    #2;
    rst = 1'b1;
    s_ready = 8'hFF;
    #1;
    chk("mr_post_idle_ready", f_ready, 0);
    next_cycle();
    #1;
    chk("mr_post_ready", f_ready, 4'b0001);
    chk("mr_post_err", f_err, 0);
    chk("mr_post_data", f_data, {96'h0, 32'h5555_AAAA});
    $display("txn after reset: master 0 read slave 3");
    next_cycle();
    m_req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end
endmodule
